// File: rtl/crc_pkg.sv
// Shared constants and the single-bit update step for the BiSS-C serial CRC-6.
package crc_pkg;

  localparam int CRC_W = 6;

  typedef logic [CRC_W-1:0] crc_t;

  // Polynomial x^6 + x + 1; the x^6 term is implicit in the shift-out.
  localparam crc_t CRC_POLY = 6'b000011;
  localparam crc_t CRC_INIT = 6'h00;

  // One Galois-form LFSR step, MSB-first data.
  function automatic crc_t crc_step(input crc_t r, input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_INIT);
  endfunction

endpackage

// File: rtl/crc_unit_edge_detect.sv
// Rising-edge detector for the bit strobe: a held-high strobe yields one pulse.
module crc_unit_edge_detect (
  input  logic clk,
  input  logic clear,
  input  logic level,
  output logic pulse
);

  logic level_d_r;

  // Delayed copy of the strobe level; cleared with the frame.
  always_ff @(posedge clk) begin
    if (clear) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level;
    end
  end

  assign pulse = level & ~level_d_r;

endmodule

// File: rtl/crc_unit.sv
// Serial CRC-6 generator/checker (x^6 + x + 1), MSB first, one bit per strobe edge.
// Define CRC_OUT_INVERT_EN to present the inverted remainder on crc.
module crc_unit
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             bitval,
  input  logic             bitstrb,
  output logic [CRC_W-1:0] crc
);

`ifdef CRC_OUT_INVERT_EN
  localparam crc_t CRC_OUT_RESET = ~CRC_INIT;
`else
  localparam crc_t CRC_OUT_RESET = CRC_INIT;
`endif

  logic strb_s;
  crc_t r_r;
  crc_t r_next_s;
  crc_t crc_next_s;
  crc_t crc_r;

  crc_unit_edge_detect u_edge (
    .clk   (clk),
    .clear (clear),
    .level (bitstrb),
    .pulse (strb_s)
  );

  // Next LFSR state and the output view of it.
  always_comb begin
    r_next_s   = r_r;
    crc_next_s = CRC_OUT_RESET;
    if (strb_s) begin
      r_next_s = crc_step(r_r, bitval);
    end else begin
      r_next_s = r_r;
    end
`ifdef CRC_OUT_INVERT_EN
    crc_next_s = ~r_next_s;
`else
    crc_next_s = r_next_s;
`endif
  end

  // LFSR and output registers; clear wins over a coincident strobe.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_r   <= CRC_INIT;
      crc_r <= CRC_OUT_RESET;
    end else begin
      r_r   <= r_next_s;
      crc_r <= crc_next_s;
    end
  end

  assign crc = crc_r;

endmodule

// File: tb/tb_crc_unit.sv
// Self-checking bench for crc_unit: directed cases plus random frames against a
// polynomial long-division reference model.
module tb_crc_unit;

  logic       clk;
  logic       clear;
  logic       bitval;
  logic       bitstrb;
  logic [5:0] crc;

  int errors;
  int checks;
  logic msg[$];

  crc_unit dut (
    .clk     (clk),
    .clear   (clear),
    .bitval  (bitval),
    .bitstrb (bitstrb),
    .crc     (crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Output view of a raw remainder in the current build.
  function automatic logic [5:0] view(input logic [5:0] x);
`ifdef CRC_OUT_INVERT_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  // M(x)*x^6 mod (x^6+x+1) by long division over the augmented message.
  function automatic logic [5:0] model();
    logic [6:0] rem;
    rem = 7'h00;
    foreach (msg[i]) begin
      rem = {rem[5:0], msg[i]};
      if (rem[6]) rem = rem ^ 7'h43;
    end
    for (int k = 0; k < 6; k++) begin
      rem = {rem[5:0], 1'b0};
      if (rem[6]) rem = rem ^ 7'h43;
    end
    return view(rem[5:0]);
  endfunction

  task automatic do_clear(input int n);
    clear   = 1'b1;
    bitstrb = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    clear = 1'b0;
    msg.delete();
  endtask

  // Present one bit: strobe high for hi cycles, then low for lo cycles.
  task automatic strobe(input logic b, input int hi, input int lo);
    bitval  = b;
    bitstrb = 1'b1;
    @(posedge clk);
    #1;
    msg.push_back(b);
    check_eq("strobe", crc, model());
    bitval = 1'($urandom);
    for (int i = 1; i < hi; i++) begin
      @(posedge clk);
      #1;
      bitval = 1'($urandom);
      check_eq("held_high", crc, model());
    end
    bitstrb = 1'b0;
    for (int i = 0; i < lo; i++) begin
      @(posedge clk);
      #1;
      bitval = 1'($urandom);
    end
    check_eq("hold_low", crc, model());
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clear   = 1'b1;
    bitval  = 1'b0;
    bitstrb = 1'b0;
    @(posedge clk);
    #1;

    // Reset and idle
    do_clear(10);
    check_eq("reset", crc, view(6'h00));
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset_idle", crc, view(6'h00));

    // Single bits
    strobe(1'b1, 1, 1);
    check_eq("single_one", crc, view(6'h03));
    strobe(1'b0, 1, 1);
    check_eq("then_zero", crc, view(6'h06));

    // Polynomial wrap: top bit reaches r[5] then feeds back
    do_clear(1);
    strobe(1'b1, 1, 1);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1, 1);
    check_eq("wrap_pre", crc, view(6'h30));
    strobe(1'b0, 1, 1);
    check_eq("wrap", crc, view(6'h23));

    // All zeros
    do_clear(2);
    for (int i = 0; i < 34; i++) strobe(1'b0, 1, 1);
    check_eq("all_zero", crc, view(6'h00));

    // Long strobe updates once
    do_clear(1);
    strobe(1'b1, 5, 2);
    check_eq("long_strobe", crc, view(6'h03));

    // Mid-frame clear coincident with a strobe edge
    do_clear(1);
    strobe(1'b1, 1, 1);
    strobe(1'b1, 1, 1);
    check_eq("two_ones", crc, view(6'h05));
    clear   = 1'b1;
    bitstrb = 1'b1;
    bitval  = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    bitstrb = 1'b0;
    msg.delete();
    check_eq("clear_wins", crc, view(6'h00));
    @(posedge clk);
    #1;
    strobe(1'b1, 1, 1);
    check_eq("after_abort", crc, view(6'h03));

    // Random frames, random strobe widths and gaps
    for (int f = 0; f < 8; f++) begin
      do_clear(int'($urandom_range(1, 3)));
      check_eq("frame_clear", crc, view(6'h00));
      for (int n = int'($urandom_range(1, 40)); n > 0; n--) begin
        strobe(1'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
